screen_blitter: RTL and testbench
=================================

SCREEN_BLITTER -- requirements
Module: screen_blitter

Interface
REQ-001 The parameter IMG_W, default 160, SHALL set the image width in pixels.
REQ-002 The parameter IMG_H, default 120, SHALL set the image height in pixels.
REQ-003 The parameter COLOR_W, default 9, SHALL set the pixel colour width in bits.
REQ-004 The parameter NUM_IMG, default 2, SHALL set the number of images stored back-to-back in the ROM.
REQ-005 The parameter ROM_LAT, default 1, SHALL set the ROM read latency in cycles, from the rom_addr register to valid rom_q (1 or 2).
REQ-006 The parameters SCR_W, default 160, and SCR_H, default 120, SHALL set the screen clip bounds.
REQ-007 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-008 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-009 start  in  1  SHALL be the one-cycle request to begin a blit; it is sampled only in IDLE.
REQ-010 img_sel  in  clog2(NUM_IMG)  SHALL select the image; it is captured at start.
REQ-011 x0  in  8  and  y0  in  7  SHALL be the screen origin; they are captured at start.
REQ-012 key_en  in  1  and  key_colour  in  COLOR_W  SHALL be the transparency enable and the transparency key; they are captured at start.
REQ-013 rom_addr  out  clog2(NUM_IMG*IMG_W*IMG_H)  SHALL be the registered ROM address.
REQ-014 rom_q  in  COLOR_W  SHALL be the ROM data.
REQ-015 vga_x  out  8,  vga_y  out  7,  vga_colour  out  COLOR_W,  vga_plot  out  1  SHALL be the registered plot interface.
REQ-016 busy  out  1  and  done  out  1  SHALL be the status outputs; done is a one-cycle pulse.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
- IDLE->RUN when start=1.
- RUN->DRAIN after the last address is issued.
- DRAIN->DONE after ROM_LAT+1 cycles.
- DONE->IDLE unconditionally.
REQ-018 On the edge that accepts start, the block SHALL capture all inputs and load rom_addr with base = img_sel*IMG_W*IMG_H.
REQ-019 In RUN, rom_addr SHALL increment by 1 per cycle and the column/row counters SHALL advance in raster order (column wraps at IMG_W-1, row increments).
REQ-020 The column, row and key-match information SHALL be delayed by ROM_LAT cycles so that it aligns with rom_q; the vga_* outputs SHALL register the aligned values one cycle later.
REQ-021 The first vga_plot for pixel 0 SHALL be high ROM_LAT+1 cycles after the start edge; pixel N-1 (N=IMG_W*IMG_H) SHALL follow at edge N+ROM_LAT.
REQ-022 done SHALL pulse, and busy SHALL fall, at edge N+ROM_LAT+1 after the start edge.
REQ-023 vga_x SHALL equal x0+col and vga_y SHALL equal y0+row; the sums are computed at 9 and 8 bits respectively so that overflow is detectable.
REQ-024 vga_plot SHALL be 0 for any pixel whose sum is >= SCR_W or >= SCR_H (clipped), and for any pixel where key_en=1 and rom_q==key_colour.
REQ-025 The vga_x, vga_y and vga_colour values of a suppressed pixel are don't-care.
REQ-026 Every pixel slot SHALL occupy exactly one cycle; suppression never alters the timing.
REQ-027 busy SHALL be 1 in RUN, DRAIN and DONE-entry; start while busy or in DONE SHALL be ignored, with no queuing.
REQ-028 Changes to img_sel, x0, y0, key_en or key_colour during a blit SHALL have no effect.
REQ-029 img_sel >= NUM_IMG SHALL be treated as image 0.

Reset
REQ-030 When reset=1, the FSM SHALL go to IDLE; rom_addr=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, busy=0, done=0.
REQ-031 Reset asserted mid-blit SHALL abort the blit immediately; no further vga_plot and no done pulse.
REQ-032 A start coincident with reset SHALL be ignored.

Verification
REQ-033 With IMG_W=4, IMG_H=2, ROM_LAT=1, img_sel=0, x0=y0=0, key_en=0: start -> vga_plot high on edges 2..9 with (x,y)=(0,0),(1,0),(2,0),(3,0),(0,1)..(3,1); colours equal ROM words 0..7; done pulses on edge 10.
REQ-034 With img_sel=1 and the same config: rom_addr sequence 8..15; done on edge 10.
REQ-035 With x0=158, y0=119, IMG_W=4: only (158,119) and (159,119) are plotted; timing is unchanged.
REQ-036 With key_en=1, key_colour=9'h1FF, and ROM words 2 and 5 equal to 1FF: exactly 6 plots; slots 2 and 5 have vga_plot=0.
REQ-037 Reset at edge 5 of a blit -> vga_plot=0 and busy=0 from edge 6; no done; a new start is accepted afterwards.
REQ-038 A second start at edges 3 and 10 -> ignored; exactly 8 plots and one done.

Source files
------------

// File: rtl/screen_blitter_if.sv
// Signal bundle between the screen blitter and its environment: request/capture
// inputs, ROM read port, plot port and status.
interface screen_blitter_if #(
   parameter int IMG_W   = 160,
   parameter int IMG_H   = 120,
   parameter int COLOR_W = 9,
   parameter int NUM_IMG = 2
);
   localparam int SEL_W  = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1;
   localparam int ADDR_W = (NUM_IMG * IMG_W * IMG_H > 1) ? $clog2(NUM_IMG * IMG_W * IMG_H) : 1;

   // start is a single-cycle request, honoured only while the blitter is idle;
   // there is no ready/ack, so a request seen while busy is simply dropped.
   logic               start;
   logic [SEL_W-1:0]   img_sel;
   logic [7:0]         x0;
   logic [6:0]         y0;
   logic               key_en;
   logic [COLOR_W-1:0] key_colour;
   logic [ADDR_W-1:0]  rom_addr;
   logic [COLOR_W-1:0] rom_q;
   logic [7:0]         vga_x;
   logic [6:0]         vga_y;
   logic [COLOR_W-1:0] vga_colour;
   logic               vga_plot;
   logic               busy;
   logic               done;

   modport master (
      output start, img_sel, x0, y0, key_en, key_colour, rom_q,
      input  rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done
   );

   modport slave (
      input  start, img_sel, x0, y0, key_en, key_colour, rom_q,
      output rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done
   );
endinterface

// File: rtl/screen_blitter.sv
// Copies one image from a back-to-back image ROM to the plot interface in raster
// order, with screen clipping and optional colour-key transparency.
module screen_blitter #(
   parameter int IMG_W   = 160,
   parameter int IMG_H   = 120,
   parameter int COLOR_W = 9,
   parameter int NUM_IMG = 2,
   parameter int ROM_LAT = 1,
   parameter int SCR_W   = 160,
   parameter int SCR_H   = 120
) (
   input  logic            clock,
   input  logic            reset,
   screen_blitter_if.slave bus,
   output logic [1:0]      dbg_state
);
   localparam int N      = IMG_W * IMG_H;
   localparam int ADDR_W = (NUM_IMG * N > 1) ? $clog2(NUM_IMG * N) : 1;
   localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int DRN_W  = $clog2(ROM_LAT + 1) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t             state, state_nx;
   logic [COL_W-1:0]   col;
   logic [ROW_W-1:0]   row;
   logic [DRN_W-1:0]   drain_cnt;
   logic [7:0]         x0_r;
   logic [6:0]         y0_r;
   logic               key_en_r;
   logic [COLOR_W-1:0] key_r;
   logic [ADDR_W-1:0]  base;
   logic               last_pix;

   // Per-slot column/row/valid, delayed to line up with rom_q.
   logic [ROM_LAT-1:0] pv;
   logic [COL_W-1:0]   pcol [ROM_LAT];
   logic [ROW_W-1:0]   prow [ROM_LAT];

   logic [8:0]         x_sum;
   logic [7:0]         y_sum;
   logic               in_bounds;
   logic               keyed;

   assign base     = (32'(bus.img_sel) < NUM_IMG) ? ADDR_W'(bus.img_sel) * ADDR_W'(N) : '0;
   assign last_pix = (col == COL_W'(IMG_W - 1)) && (row == ROW_W'(IMG_H - 1));

   assign x_sum     = {1'b0, x0_r} + 9'(pcol[ROM_LAT-1]);
   assign y_sum     = {1'b0, y0_r} + 8'(prow[ROM_LAT-1]);
   assign in_bounds = (32'(x_sum) < SCR_W) && (32'(y_sum) < SCR_H);
   assign keyed     = key_en_r && (bus.rom_q == key_r);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = RUN;
         RUN:     if (last_pix) state_nx = DRAIN;
         DRAIN:   if (drain_cnt == DRN_W'(ROM_LAT)) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         col            <= '0;
         row            <= '0;
         drain_cnt      <= '0;
         x0_r           <= '0;
         y0_r           <= '0;
         key_en_r       <= 1'b0;
         key_r          <= '0;
         pv             <= '0;
         bus.rom_addr   <= '0;
         bus.vga_x      <= '0;
         bus.vga_y      <= '0;
         bus.vga_colour <= '0;
         bus.vga_plot   <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (bus.start) begin
               x0_r         <= bus.x0;
               y0_r         <= bus.y0;
               key_en_r     <= bus.key_en;
               key_r        <= bus.key_colour;
               bus.rom_addr <= base;
               col          <= '0;
               row          <= '0;
            end
            RUN: begin
               drain_cnt <= '0;
               if (!last_pix) begin
                  bus.rom_addr <= bus.rom_addr + 1'b1;
                  if (col == COL_W'(IMG_W - 1)) begin
                     col <= '0;
                     row <= row + 1'b1;
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            DRAIN:   drain_cnt <= drain_cnt + 1'b1;
            default: ;
         endcase

         pv[0]   <= (state == RUN);
         pcol[0] <= col;
         prow[0] <= row;
         for (int i = 1; i < ROM_LAT; i++) begin
            pv[i]   <= pv[i-1];
            pcol[i] <= pcol[i-1];
            prow[i] <= prow[i-1];
         end

         bus.vga_plot   <= pv[ROM_LAT-1] && in_bounds && !keyed;
         bus.vga_x      <= x_sum[7:0];
         bus.vga_y      <= y_sum[6:0];
         bus.vga_colour <= bus.rom_q;
      end
   end

   assign bus.busy  = (state == RUN) || (state == DRAIN);
   assign bus.done  = (state == DONE);
   assign dbg_state = state;
endmodule

// File: tb/tb_screen_blitter.sv
// Randomized self-checking bench for screen_blitter: per-edge expectations are
// derived from the pixel-slot timing rules and compared against the DUT.
module tb_screen_blitter;
  localparam int IMG_W     = 4;
  localparam int IMG_H     = 2;
  localparam int COLOR_W   = 9;
  localparam int NUM_IMG   = 3;
  localparam int ROM_LAT   = 1;
  localparam int SCR_W     = 160;
  localparam int SCR_H     = 120;
  localparam int N         = IMG_W * IMG_H;
  localparam int ROM_WORDS = NUM_IMG * N;
  localparam int LEN       = N + ROM_LAT + 5;
  localparam int REC_W     = 33;

  // clock / reset
  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  always #5 clock = ~clock;

  screen_blitter_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .COLOR_W(COLOR_W), .NUM_IMG(NUM_IMG)) bif ();

  screen_blitter #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .COLOR_W(COLOR_W), .NUM_IMG(NUM_IMG),
    .ROM_LAT(ROM_LAT), .SCR_W(SCR_W), .SCR_H(SCR_H)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bif),
    .dbg_state(dbg_state)
  );

  // image ROM with one cycle of read latency
  logic [COLOR_W-1:0] rom_mem [ROM_WORDS];

  always @(posedge clock) bif.rom_q <= rom_mem[bif.rom_addr];

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [REC_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rom();
    for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = COLOR_W'($urandom_range(0, 9'h1FE));
  endtask

  // Record per edge: {addr_chk, addr[4:0], busy, done, plot, x[7:0], y[6:0], colour[8:0]}
  task automatic build_expected(input int sel, input int x0, input int y0, input int ken,
                                input int kc, input int rst_edge, output int plots);
    int base, k, xs, ys, c;
    logic busy, done, plot, achk;
    plots = 0;
    base  = ((sel < NUM_IMG) ? sel : 0) * N;
    for (int e = 0; e < LEN; e++) begin
      busy = (e <= N + ROM_LAT);
      done = (e == N + ROM_LAT + 1);
      achk = (e < N);
      plot = 1'b0;
      xs = 0; ys = 0; c = 0;
      k = e - ROM_LAT - 1;
      if (k >= 0 && k < N) begin
        xs   = x0 + k % IMG_W;
        ys   = y0 + k / IMG_W;
        c    = int'(rom_mem[base + k]);
        plot = (xs < SCR_W) && (ys < SCR_H) && !(ken != 0 && c == kc);
      end
      if (rst_edge > 0 && e >= rst_edge) begin
        busy = 1'b0; done = 1'b0; plot = 1'b0; achk = 1'b0;
      end
      if (plot) plots++;
      exp_q.push_back({achk, 5'(base + e), busy, done, plot, 8'(xs), 7'(ys), 9'(c)});
    end
  endtask

  // driver tasks
  task automatic do_reset();
    reset     = 1'b1;
    bif.start = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst rom_addr", 32'(bif.rom_addr), 0);
    check("rst vga_x", 32'(bif.vga_x), 0);
    check("rst vga_y", 32'(bif.vga_y), 0);
    check("rst vga_colour", 32'(bif.vga_colour), 0);
    check("rst vga_plot", 32'(bif.vga_plot), 0);
    check("rst busy", 32'(bif.busy), 0);
    check("rst done", 32'(bif.done), 0);
    reset     = 1'b0;
    bif.start = 1'b0;
    @(posedge clock);
    #1;
    check("post-rst busy", 32'(bif.busy), 0);
  endtask

  task automatic run_blit(input int sel, input int x0, input int y0, input int ken,
                          input int kc, input int rst_edge, input bit extra);
    int plots_exp, plots_got;
    logic [REC_W-1:0] r;
    plots_got = 0;
    build_expected(sel, x0, y0, ken, kc, rst_edge, plots_exp);
    @(negedge clock);
    bif.img_sel    = 2'(sel);
    bif.x0         = 8'(x0);
    bif.y0         = 7'(y0);
    bif.key_en     = 1'(ken);
    bif.key_colour = COLOR_W'(kc);
    bif.start      = 1'b1;
    @(posedge clock);
    #1;
    bif.start = 1'b0;
    for (int e = 0; e < LEN; e++) begin
      if (e > 0) begin
        bif.start      = extra && (e == 3 || e == 10 || e == 11);
        reset          = (rst_edge == e);
        bif.img_sel    = 2'($urandom);
        bif.x0         = 8'($urandom);
        bif.y0         = 7'($urandom);
        bif.key_en     = 1'($urandom);
        bif.key_colour = COLOR_W'($urandom);
        @(posedge clock);
        #1;
      end
      r = exp_q.pop_front();
      check($sformatf("busy e%0d", e), 32'(bif.busy), 32'(r[26]));
      check($sformatf("done e%0d", e), 32'(bif.done), 32'(r[25]));
      check($sformatf("plot e%0d", e), 32'(bif.vga_plot), 32'(r[24]));
      if (r[24]) begin
        check($sformatf("vga_x e%0d", e), 32'(bif.vga_x), 32'(r[23:16]));
        check($sformatf("vga_y e%0d", e), 32'(bif.vga_y), 32'(r[15:9]));
        check($sformatf("colour e%0d", e), 32'(bif.vga_colour), 32'(r[8:0]));
      end
      if (r[32]) check($sformatf("rom_addr e%0d", e), 32'(bif.rom_addr), 32'(r[31:27]));
      if (bif.vga_plot === 1'b1) plots_got++;
    end
    reset     = 1'b0;
    bif.start = 1'b0;
    check("plot count", 32'(plots_got), 32'(plots_exp));
  endtask

  initial begin
    int sel, x0, y0, ken, kc, rst_edge;
    bit extra;
    reset          = 1'b1;
    bif.start      = 1'b0;
    bif.img_sel    = '0;
    bif.x0         = '0;
    bif.y0         = '0;
    bif.key_en     = 1'b0;
    bif.key_colour = '0;
    fill_rom();
    do_reset();

    run_blit(0, 0, 0, 0, 0, 0, 1'b0);
    run_blit(1, 0, 0, 0, 0, 0, 1'b0);
    run_blit(0, 158, 119, 0, 0, 0, 1'b0);
    rom_mem[2] = 9'h1FF;
    rom_mem[5] = 9'h1FF;
    run_blit(0, 0, 0, 1, 9'h1FF, 0, 1'b0);
    run_blit(0, 0, 0, 0, 0, 5, 1'b0);
    run_blit(2, 0, 0, 0, 0, 0, 1'b0);
    run_blit(0, 0, 0, 0, 0, 0, 1'b1);
    run_blit(3, 10, 20, 0, 0, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      fill_rom();
      sel      = $urandom_range(0, 3);
      x0       = ($urandom_range(0, 1) != 0) ? $urandom_range(150, 159) : $urandom_range(0, 255);
      y0       = ($urandom_range(0, 1) != 0) ? $urandom_range(110, 119) : $urandom_range(0, 127);
      ken      = $urandom_range(0, 1);
      kc       = int'(rom_mem[((sel < NUM_IMG) ? sel : 0) * N + $urandom_range(0, N - 1)]);
      rst_edge = ($urandom_range(0, 3) == 0) ? $urandom_range(1, LEN - 1) : 0;
      extra    = (rst_edge == 0) && ($urandom_range(0, 1) != 0);
      run_blit(sel, x0, y0, ken, kc, rst_edge, extra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
